vote_tally: RTL
===============

# vote_tally

Ballot-collection and tally block for the voting machine. Consumes one-hot ballots for candidates A, B and C over a valid/ready handshake while a poll is open. It keeps a saturating count per candidate plus a count of malformed ballots. When the poll closes it produces a registered winner/tie result. It sits downstream of the voter input logic, at the receiving end of the A/B/C ballot lines.

## Interface
Parameters:
- CNT_W, 8: width of every counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- open_poll  input  1  single-cycle request to clear the tallies and open a poll.
- close_poll  input  1  single-cycle request to close the open poll.
- vote_valid  input  1  a ballot is presented on vote_sel.
- vote_sel  input  3  ballot as {A,B,C}; a legal ballot is exactly one bit set.
- vote_ready  output  1  high only while in OPEN; a ballot transfers when vote_valid && vote_ready at a clock edge.
- poll_open  output  1  high while in OPEN.
- cnt_a, cnt_b, cnt_c  output  CNT_W  per-candidate tallies.
- invalid_cnt  output  CNT_W  number of accepted ballots that were not one-hot.
- overflow  output  1  sticky; set when any counter would pass its maximum.
- winner  output  2  0 = none/tie, 1 = A, 2 = B, 3 = C.
- tie  output  1  the maximum nonzero count is shared by two or more candidates.
- done  output  1  result valid; high only in DONE.

## Operation
- FSM states: IDLE, OPEN, COMPARE, DONE.
- On rst_n=0, at the clock edge:
  - state = IDLE.
  - All counters = 0.
  - winner = 0; tie, overflow, done, poll_open and vote_ready = 0.
- IDLE:
  - open_poll -> OPEN. Clear all counters, overflow, winner, tie.
  - close_poll is ignored.
- OPEN:
  - Each transferred ballot increments exactly one counter at that edge: cnt_a for 3'b100, cnt_b for 3'b010, cnt_c for 3'b001, otherwise invalid_cnt (covers 000, 110, 111, ...).
  - Saturation: a counter at all-ones holds its value, and overflow is set and stays set until the next open_poll.
  - close_poll -> COMPARE.
  - open_poll while in OPEN is ignored.
- COMPARE (one cycle): evaluate the three candidate counts, register the result, -> DONE.
  - Unique maximum -> winner = that candidate, tie = 0.
  - Maximum shared by two or more candidates, max > 0 -> winner = 0, tie = 1.
  - All three counts zero -> winner = 0, tie = 0.
  - invalid_cnt never affects the winner.
- DONE:
  - Hold all counters and results; done = 1.
  - open_poll -> OPEN with counters and results cleared. close_poll is ignored.
- Simultaneous events:
  - Ballot transfer and close_poll at the same OPEN edge: the ballot is counted, then the state goes to COMPARE. The compare uses the updated count.
  - open_poll and close_poll together in OPEN: close wins.
  - open_poll and close_poll together in IDLE or DONE: open wins.
- Reset asserted in any state, including mid-poll: all tallies are lost and the block returns to IDLE.

## Timing
- vote_ready = poll_open = (state == OPEN). Both are registered, with no combinational path from vote_valid.
- Counter update latency is 1 edge: a ballot transferred at edge k is visible on cnt_* after edge k.
- Close latency:
  - close_poll sampled at edge k -> COMPARE after k.
  - winner/tie registered and done = 1 after edge k+1.
  - vote_ready drops after edge k, so no ballot transfers at edge k+1.
- open_poll sampled at edge k -> OPEN after k, counters read 0 after k, and the first ballot can transfer at edge k+1.
- done falls at the edge that samples open_poll or reset.
- Ballots presented outside OPEN are not transferred and do not stall anything.

## Test plan
- Reset, open, then 3 A, 2 B, 1 C ballots, close -> cnt_a=3, cnt_b=2, cnt_c=1, winner=1, tie=0, done=1 two edges after close is sampled.
- 2 A, 2 C, 1 B, plus ballots 000 and 111 -> invalid_cnt=2, winner=0, tie=1.
- CNT_W=2 with 5 B ballots -> cnt_b=3 (saturated), overflow=1, winner=2. A new open_poll clears overflow.
- A C ballot transferring on the same edge as close_poll -> cnt_c includes it. vote_ready=0 on the next edge; a ballot held valid there is not counted.
- rst_n=0 for one edge mid-poll with cnt_a=4 -> all counters 0, state IDLE. Ballots are then ignored until open_poll.
- Open then close with no ballots -> winner=0, tie=0, done=1. Reopening from DONE clears done and restarts counting from 0.

Source files
------------

// File: rtl/vote_tally.sv
// vote_tally: ballot collection and tally for a three-candidate poll.
// Accepts one-hot ballots over valid/ready while a poll is open and keeps
// saturating per-candidate counts and a malformed-ballot count. Closing the
// poll produces a registered winner/tie result.
module vote_tally #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             open_poll,
    input  logic             close_poll,
    input  logic             vote_valid,
    input  logic [2:0]       vote_sel,
    output logic             vote_ready,
    output logic             poll_open,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic             overflow,
    output logic [1:0]       winner,
    output logic             tie,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    state_t     state_next;
    logic       start_poll;
    logic       accept;
    logic [1:0] winner_next;
    logic       tie_next;

    // A new poll can only be started from IDLE or DONE; open_poll in OPEN is ignored.
    assign start_poll = open_poll && ((state == IDLE) || (state == DONE));
    // Ballots only transfer while the poll is open.
    assign accept     = vote_valid && (state == OPEN);
    assign vote_ready = poll_open;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; close has priority in OPEN simply because open is not decoded there.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (open_poll)  state_next = OPEN;
            OPEN:    if (close_poll) state_next = COMPARE;
            COMPARE: state_next = DONE;
            DONE:    if (open_poll)  state_next = OPEN;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they carry no decode glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            poll_open <= 1'b0;
            done      <= 1'b0;
        end else begin
            poll_open <= (state_next == OPEN);
            done      <= (state_next == DONE);
        end
    end

    // Tally counters: one increment per transferred ballot, saturating with a sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n || start_poll) begin
            cnt_a       <= '0;
            cnt_b       <= '0;
            cnt_c       <= '0;
            invalid_cnt <= '0;
            overflow    <= 1'b0;
        end else if (accept) begin
            case (vote_sel)
                3'b100: begin
                    if (cnt_a == CNT_MAX) overflow <= 1'b1;
                    else                  cnt_a <= cnt_a + CNT_ONE;
                end
                3'b010: begin
                    if (cnt_b == CNT_MAX) overflow <= 1'b1;
                    else                  cnt_b <= cnt_b + CNT_ONE;
                end
                3'b001: begin
                    if (cnt_c == CNT_MAX) overflow <= 1'b1;
                    else                  cnt_c <= cnt_c + CNT_ONE;
                end
                default: begin
                    if (invalid_cnt == CNT_MAX) overflow <= 1'b1;
                    else                        invalid_cnt <= invalid_cnt + CNT_ONE;
                end
            endcase
        end
    end

    // Winner decision: a strict maximum wins; a shared nonzero maximum is a tie.
    always_comb begin
        winner_next = 2'd0;
        tie_next    = 1'b0;
        if ((cnt_a > cnt_b) && (cnt_a > cnt_c)) begin
            winner_next = 2'd1;
        end else if ((cnt_b > cnt_a) && (cnt_b > cnt_c)) begin
            winner_next = 2'd2;
        end else if ((cnt_c > cnt_a) && (cnt_c > cnt_b)) begin
            winner_next = 2'd3;
        end else if ((cnt_a != '0) || (cnt_b != '0) || (cnt_c != '0)) begin
            tie_next = 1'b1;
        end
    end

    // Result register: captured during the single COMPARE cycle, cleared on a new poll.
    always_ff @(posedge clk) begin
        if (!rst_n || start_poll) begin
            winner <= 2'd0;
            tie    <= 1'b0;
        end else if (state == COMPARE) begin
            winner <= winner_next;
            tie    <= tie_next;
        end
    end

endmodule
